// File: rtl/mcu_spi_arb_pkg.sv
// Shared types and constants for the MCU SPI source arbiter.
package mcu_spi_arb_pkg;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned SW_CNT_W    = 8;

    typedef enum logic [2:0] {
        INT_IDLE = 3'd0,
        INT_BUSY = 3'd1,
        TO_EXT   = 3'd2,
        EXT_IDLE = 3'd3,
        EXT_BUSY = 3'd4,
        TO_INT   = 3'd5
    } arb_state_t;

endpackage

// File: rtl/mcu_spi_source_arbiter_sync2.sv
// Multi-flop synchronizer for a single asynchronous level, with a selectable reset value.
module sync2
    import mcu_spi_arb_pkg::*;
#(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sr_q;
    logic [SYNC_STAGES-1:0] sr_d;

    // Shift the raw level in at the bottom of the chain
    always_comb begin
        sr_d = {sr_q[SYNC_STAGES-2:0], d};
    end

    // Synchronizer register chain
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q = sr_q[SYNC_STAGES-1];

endmodule

// File: rtl/mcu_spi_source_arbiter.sv
// Selects the SPI master (BL616 or M0S Dock) driving the MCU port. Switches only
// between transactions, after debounce, with a forced-idle gap and optional fallback.
module mcu_spi_source_arbiter
    import mcu_spi_arb_pkg::*;
#(
    parameter int unsigned DEBOUNCE       = 4,
    parameter int unsigned GAP            = 16,
    parameter int unsigned RETURN_TIMEOUT = 0,
    parameter int unsigned CNT_W          = 24
) (
    input  logic                clk32,
    input  logic                por,
    input  logic                int_sclk,
    input  logic                int_csn,
    input  logic                int_mosi,
    input  logic                ext_sclk,
    input  logic                ext_csn,
    input  logic                ext_mosi,
    input  logic                force_int,
    output logic                sel_sclk,
    output logic                sel_csn,
    output logic                sel_mosi,
    output logic                ext_active,
    output logic                switching,
    output logic [SW_CNT_W-1:0] switch_cnt
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP - 1);
    localparam logic [CNT_W-1:0] RT_LAST  = CNT_W'(RETURN_TIMEOUT - 1);
    localparam logic             RT_EN    = (RETURN_TIMEOUT != 0);

    logic int_csn_s;
    logic ext_csn_s;

    sync2 #(.RESET_VAL(1'b1)) u_sync_int (
        .clk (clk32),
        .rst (por),
        .d   (int_csn),
        .q   (int_csn_s)
    );

    sync2 #(.RESET_VAL(1'b1)) u_sync_ext (
        .clk (clk32),
        .rst (por),
        .d   (ext_csn),
        .q   (ext_csn_s)
    );

    arb_state_t          state_q, state_d;
    logic [CNT_W-1:0]    deb_cnt_q, deb_cnt_d;
    logic [CNT_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0]    idle_cnt_q, idle_cnt_d;
    logic                ext_active_q, ext_active_d;
    logic                switching_q, switching_d;
    logic [SW_CNT_W-1:0] switch_cnt_q, switch_cnt_d;
    logic                sw_done;

    // Next-state, counter and status logic; every state change clears all counters
    always_comb begin
        state_d      = state_q;
        deb_cnt_d    = deb_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        ext_active_d = ext_active_q;
        switch_cnt_d = switch_cnt_q;
        sw_done      = 1'b0;

        case (state_q)
            INT_IDLE: begin
                if (!int_csn_s) begin
                    state_d = INT_BUSY;
                end else if (!ext_csn_s && !force_int) begin
                    if (deb_cnt_q == DEB_LAST) begin
                        state_d = TO_EXT;
                    end else begin
                        deb_cnt_d = deb_cnt_q + 1'b1;
                    end
                end else begin
                    deb_cnt_d = '0;
                end
            end
            INT_BUSY: begin
                deb_cnt_d = '0;
                if (int_csn_s) begin
                    state_d = INT_IDLE;
                end
            end
            TO_EXT: begin
                if (force_int) begin
                    state_d = TO_INT;
                end else if (gap_cnt_q >= GAP_LAST && ext_csn_s) begin
                    state_d      = EXT_IDLE;
                    ext_active_d = 1'b1;
                    sw_done      = 1'b1;
                end else if (gap_cnt_q != '1) begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            EXT_IDLE: begin
                if (!ext_csn_s) begin
                    state_d = EXT_BUSY;
                end else if (force_int || (RT_EN && idle_cnt_q == RT_LAST)) begin
                    state_d = TO_INT;
                end else if (idle_cnt_q != '1) begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            EXT_BUSY: begin
                if (ext_csn_s) begin
                    state_d = EXT_IDLE;
                end
            end
            TO_INT: begin
                if (gap_cnt_q >= GAP_LAST && int_csn_s) begin
                    state_d      = INT_IDLE;
                    ext_active_d = 1'b0;
                    sw_done      = 1'b1;
                end else if (gap_cnt_q != '1) begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = INT_IDLE;
            end
        endcase

        if (sw_done && switch_cnt_q != '1) begin
            switch_cnt_d = switch_cnt_q + 1'b1;
        end

        if (state_d != state_q) begin
            deb_cnt_d  = '0;
            gap_cnt_d  = '0;
            idle_cnt_d = '0;
        end

        switching_d = (state_d == TO_EXT) || (state_d == TO_INT);
    end

    // Arbiter state and registered status outputs
    always_ff @(posedge clk32) begin
        if (por) begin
            state_q      <= INT_IDLE;
            deb_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            idle_cnt_q   <= '0;
            ext_active_q <= 1'b0;
            switching_q  <= 1'b0;
            switch_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            deb_cnt_q    <= deb_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            ext_active_q <= ext_active_d;
            switching_q  <= switching_d;
            switch_cnt_q <= switch_cnt_d;
        end
    end

    // Pin mux from raw inputs gated by the registered state: no added latency
    always_comb begin
        sel_csn  = 1'b1;
        sel_sclk = 1'b0;
        sel_mosi = 1'b0;
        case (state_q)
            INT_IDLE, INT_BUSY: begin
                sel_csn  = int_csn;
                sel_sclk = int_sclk;
                sel_mosi = int_mosi;
            end
            EXT_IDLE, EXT_BUSY: begin
                sel_csn  = ext_csn;
                sel_sclk = ext_sclk;
                sel_mosi = ext_mosi;
            end
            default: begin
                sel_csn  = 1'b1;
                sel_sclk = 1'b0;
                sel_mosi = 1'b0;
            end
        endcase
    end

    assign ext_active = ext_active_q;
    assign switching  = switching_q;
    assign switch_cnt = switch_cnt_q;

endmodule
